// File: rtl/dcache_pkg.sv
// +--------------------------------------------------------------------------+
// | dcache_pkg: geometry, address-field slices and FSM encoding for dcache   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package dcache_pkg;

  localparam int LINES     = 32;
  localparam int LINE_BITS = 256;
  localparam int ADDR_W    = 32;
  localparam int WORD_BITS = 32;
  localparam int WORDS     = LINE_BITS / WORD_BITS;
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam int WORD_W    = $clog2(WORDS);
  localparam int IDX_W     = $clog2(LINES);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;

  localparam int WORD_LSB  = 2;
  localparam int IDX_LSB   = OFF_W;
  localparam int TAG_LSB   = OFF_W + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WBACK  = 2'd1,
    ST_REFILL = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_array.sv
// +--------------------------------------------------------------------------+
// | dcache_data_array: line storage, combinational read, line or word write  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_data_array #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int DATA_W    = 32,
  localparam int IDX_BITS = $clog2(NUM_LINES),
  localparam int SEL_BITS = $clog2(LINE_W / DATA_W)
) (
  input  logic                clk_i,
  input  logic [IDX_BITS-1:0] idx_i,
  output logic [LINE_W-1:0]   rd_line_o,
  input  logic                line_we_i,
  input  logic [LINE_W-1:0]   line_i,
  input  logic                word_we_i,
  input  logic [SEL_BITS-1:0] word_sel_i,
  input  logic [DATA_W-1:0]   word_i
);

  logic [LINE_W-1:0] mem_q [NUM_LINES];

  assign rd_line_o = mem_q[idx_i];

  // A line install already carries any merged store word, so it takes priority.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      mem_q[idx_i] <= line_i;
    end else if (word_we_i) begin
      mem_q[idx_i][DATA_W*word_sel_i +: DATA_W] <= word_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// +--------------------------------------------------------------------------+
// | dcache_ctrl: direct-mapped write-back/write-allocate data cache control. |
// | Optional DCACHE_STATS_EN adds saturating hit/miss counters. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_BITS-1:0] cpu_wdata_i,
  output logic [WORD_BITS-1:0] cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              unused_addr_lsbs;

  assign word             = cpu_addr_i[WORD_LSB +: WORD_W];
  assign idx              = cpu_addr_i[IDX_LSB +: IDX_W];
  assign tag              = cpu_addr_i[TAG_LSB +: TAG_W];
  assign unused_addr_lsbs = ^cpu_addr_i[WORD_LSB-1:0];

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [LINES];
  logic [LINE_BITS-1:0] refill_q, refill_d;
  logic [LINE_BITS-1:0] rd_line, merged_line;
  logic                 hit, tag_we, line_we, word_we;

  assign hit         = valid_q[idx] & (tag_q[idx] == tag);
  assign cpu_stall_o = cpu_req_i & ((state_q != ST_IDLE) | !hit);
  assign cpu_rdata_o = hit ? rd_line[WORD_BITS*word +: WORD_BITS] : '0;

  dcache_data_array #(
    .NUM_LINES (LINES),
    .LINE_W    (LINE_BITS),
    .DATA_W    (WORD_BITS)
  ) u_data (
    .clk_i      (clk_i),
    .idx_i      (idx),
    .rd_line_o  (rd_line),
    .line_we_i  (line_we),
    .line_i     (merged_line),
    .word_we_i  (word_we),
    .word_sel_i (word),
    .word_i     (cpu_wdata_i)
  );

  // Write-allocate: a missing store lands in the refilled line before install.
  always_comb begin
    merged_line = refill_q;
    if (cpu_we_i) begin
      merged_line[WORD_BITS*word +: WORD_BITS] = cpu_wdata_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    refill_d    = refill_q;
    tag_we      = 1'b0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) begin
              word_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else if (valid_q[idx] & dirty_q[idx]) begin
            state_d = ST_WBACK;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_WBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(tag_q[idx], idx);
        mem_wdata_o = rd_line;
        if (mem_ack_i) begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr(tag, idx);
        if (mem_ack_i) begin
          refill_d = mem_rdata_i;
          state_d  = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        line_we      = 1'b1;
        tag_we       = 1'b1;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = cpu_we_i;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    refill_q <= refill_d;
    if (tag_we) begin
      tag_q[idx] <= tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        prev_update_q, prev_update_d;

  // The hit that follows UPDATE is the retry of an already-counted miss.
  always_comb begin
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    prev_update_d = (state_q == ST_UPDATE);
    if ((state_q == ST_IDLE) && cpu_req_i && hit && !prev_update_q && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE) && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      prev_update_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      prev_update_q <= prev_update_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_dcache_ctrl: directed plus randomized bench against a line-level model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_ctrl;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Default contents of memory lines never written back.
  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ (32'h01010101 * 32'(w)) ^ 32'hA5A50000;
    return l;
  endfunction

  // Behavioural cache model: one entry per line, words held as an array.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [31:0]  m_data  [32][8];
  logic [255:0] mdl_mem [logic [31:0]];
  int           hit_model = 0, miss_model = 0;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;
  txn_t         txn_q[$];
  logic [255:0] mem_store [logic [31:0]];

  logic [31:0]  last_rdata, last_wb_addr, last_rf_addr;
  logic [255:0] last_wb_data;
  int           last_ntxn;

  // Memory responder: ack LAT cycles after each request begins.
  initial begin
    bit active;
    int cnt;
    active      = 0;
    cnt         = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        active    = 0;
        mem_ack_i = 1'b0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          active    = 0;
        end
        if (!mem_req_o) begin
          active = 0;
        end else if (!active) begin
          active = 1;
          cnt    = 0;
        end else begin
          cnt++;
          if (cnt == LAT) begin
            txn_t t;
            t.we   = mem_we_o;
            t.addr = mem_addr_o;
            t.data = mem_wdata_o;
            txn_q.push_back(t);
            if (mem_we_o) mem_store[mem_addr_o] = mem_wdata_o;
            else mem_rdata_i = mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o] : pattern(mem_addr_o);
            mem_ack_i = 1'b1;
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    hit_model  = 0;
    miss_model = 0;
  endtask

  task automatic idle(input int n);
    cpu_req_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      chk("idle_stall", cpu_stall_o, 1'b0);
      chk("idle_mem_req", mem_req_o, 1'b0);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    logic [4:0]   idx;
    logic [2:0]   w;
    logic [21:0]  tg;
    bit           hit, wb, er;
    int           n_stall, n_txn;
    logic [31:0]  laddr, vaddr, exp_rd;
    logic [255:0] vline, nline;
    txn_t         t;
    idx   = addr[9:5];
    w     = addr[4:2];
    tg    = addr[31:10];
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    wb    = !hit && m_valid[idx] && m_dirty[idx];
    n_stall = hit ? 0 : (wb ? 2*(LAT+1) + 2 : (LAT+1) + 2);
    n_txn = hit ? 0 : (wb ? 2 : 1);
    laddr = {addr[31:5], 5'b0};
    vaddr = {m_tag[idx], idx, 5'b0};
    for (int i = 0; i < 8; i++) vline[i*32 +: 32] = m_data[idx][i];
    nline = mdl_mem.exists(laddr) ? mdl_mem[laddr] : pattern(laddr);
    exp_rd = hit ? m_data[idx][w] : nline[w*32 +: 32];
    txn_q.delete();
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    for (int c = 0; c <= n_stall; c++) begin
      @(negedge clk_i);
      chk("stall", cpu_stall_o, c < n_stall);
      er = (c >= 1) && (c <= n_stall - 2);
      chk("mem_req", mem_req_o, er);
      if (er) begin
        if (wb && c <= LAT + 1) begin
          chk("wb_we", mem_we_o, 1'b1);
          chk("wb_addr", mem_addr_o, vaddr);
          if (c == 1) chk("wb_data", mem_wdata_o, vline);
        end else begin
          chk("rf_we", mem_we_o, 1'b0);
          chk("rf_addr", mem_addr_o, laddr);
        end
      end
      if (c == n_stall) begin
        last_rdata = cpu_rdata_o;
        if (!we) chk("load_data", cpu_rdata_o, exp_rd);
      end
    end
    @(posedge clk_i); #1;
    last_ntxn = txn_q.size();
    chk("txn_count", last_ntxn, n_txn);
    while (txn_q.size() > 0) begin
      t = txn_q.pop_front();
      if (t.we) begin
        last_wb_addr = t.addr;
        last_wb_data = t.data;
      end else begin
        last_rf_addr = t.addr;
      end
    end
    if (hit) hit_model++;
    else begin
      miss_model++;
      if (wb) mdl_mem[vaddr] = vline;
      for (int i = 0; i < 8; i++) m_data[idx][i] = nline[i*32 +: 32];
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 0;
    end
    if (we) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1;
    end
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt_o, hit_model);
    chk("miss_cnt", miss_cnt_o, miss_model);
`endif
  endtask

  initial begin
    logic [31:0] addr;
    logic [21:0] tg;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);
    chk("rst_stall", cpu_stall_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle(2);

    access(0, 32'h40, 0);
    chk("s1_rf_addr", last_rf_addr, 32'h40);
    chk("s1_rdata", last_rdata, 32'hA5A50040);

    access(1, 32'h44, 32'hDEADBEEF);
    chk("s2_no_mem", last_ntxn, 0);
    access(0, 32'h44, 0);
    chk("s2_rdata", last_rdata, 32'hDEADBEEF);

    access(0, 32'h440, 0);
    chk("s3_wb_addr", last_wb_addr, 32'h40);
    chk("s3_wb_word1", last_wb_data[63:32], 32'hDEADBEEF);
    chk("s3_rf_addr", last_rf_addr, 32'h440);

    access(1, 32'h800, 32'h11223344);
    chk("s4_ntxn", last_ntxn, 1);
    chk("s4_rf_addr", last_rf_addr, 32'h800);
`ifdef DCACHE_STATS_EN
    chk("s6_miss_cnt", miss_cnt_o, 32'd3);
    chk("s6_hit_cnt", hit_cnt_o, 32'd2);
`endif
    access(0, 32'h800, 0);
    chk("s4_rdata", last_rdata, 32'h11223344);
    access(0, 32'h1800, 0);
    chk("s4_dirty_wb", last_wb_addr, 32'h800);
    access(0, 32'h800, 0);
    chk("s4_reload", last_rdata, 32'h11223344);
    idle(1);

    // Abort a refill with reset.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hC40; cpu_wdata_i = '0;
    repeat (5) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("s5_in_refill", mem_req_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; cpu_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_reset();
    txn_q.delete();
    @(negedge clk_i);
    chk("s5_mem_req", mem_req_o, 1'b0);
    chk("s5_stall", cpu_stall_o, 1'b0);
    chk("s5_mem_addr", mem_addr_o, 32'h0);
    chk("s5_rdata", cpu_rdata_o, 32'h0);
    idle(2);
    access(0, 32'h40, 0);
    chk("s5_remiss", last_ntxn, 1);
    chk("s5_rf_addr", last_rf_addr, 32'h40);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       tg = 22'h0;
        1:       tg = 22'h1;
        2:       tg = 22'h3FFFFF;
        default: tg = 22'h2AAAAA;
      endcase
      addr = {tg, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
